// File: rtl/sobel_pkg.sv
// sobel_pkg: shared mode constants, width helper and default threshold for the Sobel edge path.
package sobel_pkg;
    localparam logic SOBEL_L2 = 1'b0;
    localparam logic SOBEL_L1 = 1'b1;
    localparam int SOBEL_DEF_THRESH = 770;
    function automatic int sobel_grad_w(input int data_w);
        return 2 * data_w + 6;
    endfunction
endpackage

// File: rtl/sobel_window3x3.sv
// sobel_window3x3: two cascaded line RAMs feeding a 3x3 window whose bottom-right tap is the live pixel.
module sobel_window3x3 #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640,
    parameter int POS_W  = 10
) (
    input  logic              video_pclk,
    input  logic              sys_rst_n,
    input  logic              de,
    input  logic [DATA_W-1:0] data,
    input  logic [POS_W-1:0]  xpos,
    output logic [DATA_W-1:0] p11, p12, p13,
    output logic [DATA_W-1:0] p21, p22, p23,
    output logic [DATA_W-1:0] p31, p32, p33,
    output logic              win_valid
);
    localparam int AW = $clog2(IMG_W);
    logic [DATA_W-1:0] line0 [IMG_W];
    logic [DATA_W-1:0] line1 [IMG_W];
    logic [AW-1:0]     addr;
    logic              in_rng;
    logic [DATA_W-1:0] t0, t1;
    assign in_rng = int'(xpos) < IMG_W;
    assign addr   = AW'(xpos);
    assign t0     = in_rng ? line0[addr] : '0;
    assign t1     = in_rng ? line1[addr] : '0;
    // Read-before-write: line1 takes line0's old value at the same address.
    always_ff @(posedge video_pclk) begin
        if (de && in_rng) begin
            line0[addr] <= data;
            line1[addr] <= line0[addr];
        end
    end
    always_ff @(posedge video_pclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            {p11, p12, p13, p21, p22, p23, p31, p32, p33} <= '0;
            win_valid <= 1'b0;
        end else begin
            win_valid <= de && in_rng;
            if (de) begin
                {p11, p12, p13} <= {p12, p13, t1};
                {p21, p22, p23} <= {p22, p23, t0};
                {p31, p32, p33} <= {p32, p33, data};
            end
        end
    end
endmodule

// File: rtl/sobel_edge_param.sv
// sobel_edge_param: five-stage Sobel gradient, L1/L2 threshold and scaled magnitude with
// frame-synchronous config shadowing and a matching sideband delay line.
module sobel_edge_param import sobel_pkg::*; #(
    parameter  int DATA_W = 8,
    parameter  int IMG_W  = 640,
    parameter  int POS_W  = 10,
    localparam int GRAD_W = sobel_grad_w(DATA_W)
) (
    input  logic              video_pclk,
    input  logic              sys_rst_n,
    input  logic              pre_video_vsync,
    input  logic              pre_video_hsync,
    input  logic              pre_video_de,
    input  logic [DATA_W-1:0] pre_video_data,
    input  logic [POS_W-1:0]  pre_video_xpos,
    input  logic [POS_W-1:0]  pre_video_ypos,
    input  logic              cfg_mode,
    input  logic [GRAD_W-1:0] cfg_thresh,
    output logic              post_video_vsync,
    output logic              post_video_hsync,
    output logic              post_video_de,
    output logic              post_video_edge,
    output logic [DATA_W-1:0] post_video_mag,
    output logic [POS_W-1:0]  post_video_xpos,
    output logic [POS_W-1:0]  post_video_ypos
);
    localparam int SW  = DATA_W + 4;
    localparam int SBW = 2 * POS_W + 3;
    logic [DATA_W-1:0]    p11, p12, p13, p21, p22, p23, p31, p32, p33;
    logic                 win_valid;
    logic [SBW-1:0]       sb [5];
    logic [POS_W-1:0]     x1, y1;
    logic                 v2, v3, v4;
    logic signed [SW-1:0] gx, gy;
    logic [SW-1:0]        ax_c, ay_c, ax, ay, l1;
    logic [2*SW-1:0]      sqx, sqy;
    logic [GRAD_W-1:0]    l2, sh_thresh;
    logic                 sh_mode, vs_q, hit;

    sobel_window3x3 #(.DATA_W(DATA_W), .IMG_W(IMG_W), .POS_W(POS_W)) u_win (
        .video_pclk(video_pclk), .sys_rst_n(sys_rst_n),
        .de(pre_video_de), .data(pre_video_data), .xpos(pre_video_xpos),
        .p11(p11), .p12(p12), .p13(p13),
        .p21(p21), .p22(p22), .p23(p23),
        .p31(p31), .p32(p32), .p33(p33),
        .win_valid(win_valid)
    );

    assign x1   = sb[0][2*POS_W-1:POS_W];
    assign y1   = sb[0][POS_W-1:0];
    assign ax_c = gx[SW-1] ? -gx : gx;
    assign ay_c = gy[SW-1] ? -gy : gy;
    assign hit  = sh_mode == SOBEL_L1 ? GRAD_W'(l1) >= sh_thresh : l2 >= sh_thresh;
    assign {post_video_vsync, post_video_hsync, post_video_de,
            post_video_xpos, post_video_ypos} = sb[4];

    always_ff @(posedge video_pclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vs_q      <= 1'b0;
            sh_thresh <= '1;
            sh_mode   <= SOBEL_L2;
            for (int i = 0; i < 5; i++) sb[i] <= '0;
            {v2, v3, v4} <= '0;
            gx  <= '0;
            gy  <= '0;
            ax  <= '0;
            ay  <= '0;
            sqx <= '0;
            sqy <= '0;
            l1  <= '0;
            l2  <= '0;
            post_video_edge <= 1'b0;
            post_video_mag  <= '0;
        end else begin
            vs_q <= pre_video_vsync;
            if (pre_video_vsync && !vs_q) begin
                sh_thresh <= cfg_thresh;
                sh_mode   <= cfg_mode;
            end
            sb[0] <= {pre_video_vsync, pre_video_hsync, pre_video_de, pre_video_xpos, pre_video_ypos};
            for (int i = 1; i < 5; i++) sb[i] <= sb[i-1];
            // Window is complete only once two earlier columns and rows exist.
            v2 <= win_valid && x1 >= POS_W'(2) && y1 >= POS_W'(2);
            gx <= SW'(p13) + SW'({p23, 1'b0}) + SW'(p33) - SW'(p11) - SW'({p21, 1'b0}) - SW'(p31);
            gy <= SW'(p31) + SW'({p32, 1'b0}) + SW'(p33) - SW'(p11) - SW'({p12, 1'b0}) - SW'(p13);
            v3  <= v2;
            ax  <= ax_c;
            ay  <= ay_c;
            sqx <= (2*SW)'(ax_c) * (2*SW)'(ax_c);
            sqy <= (2*SW)'(ay_c) * (2*SW)'(ay_c);
            v4 <= v3;
            l1 <= ax + ay;
            l2 <= GRAD_W'(sqx + sqy);
            post_video_edge <= v4 && hit;
            post_video_mag  <= v4 ? l1[DATA_W+2:3] : '0;
        end
    end
endmodule

// File: tb/tb_sobel_edge_param.sv
// tb_sobel_edge_param: random and directed frames checked against an image-level Sobel model.
module tb_sobel_edge_param;
    localparam int DW = 8, IW = 640, PW = 10, GW = 22;
    logic          video_pclk = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic          pre_video_vsync = 1'b0, pre_video_hsync = 1'b0, pre_video_de = 1'b0;
    logic [DW-1:0] pre_video_data = '0;
    logic [PW-1:0] pre_video_xpos = '0, pre_video_ypos = '0;
    logic          cfg_mode = 1'b0;
    logic [GW-1:0] cfg_thresh = '0;
    logic          post_video_vsync, post_video_hsync, post_video_de, post_video_edge;
    logic [DW-1:0] post_video_mag;
    logic [PW-1:0] post_video_xpos, post_video_ypos;
    logic [31:0]   outs;
    logic [7:0]    img [0:7][0:639];
    int            checks = 0, errors = 0;
    typedef struct {logic [31:0] v; bit skip;} exp_t;
    exp_t          q[$];
    logic [GW-1:0] m_th = '1;
    logic          m_mode = 1'b0, vs_prev = 1'b0;
    bit            m_skip = 1'b1;

    sobel_edge_param #(.DATA_W(DW), .IMG_W(IW), .POS_W(PW)) dut (
        .video_pclk(video_pclk), .sys_rst_n(sys_rst_n),
        .pre_video_vsync(pre_video_vsync), .pre_video_hsync(pre_video_hsync),
        .pre_video_de(pre_video_de), .pre_video_data(pre_video_data),
        .pre_video_xpos(pre_video_xpos), .pre_video_ypos(pre_video_ypos),
        .cfg_mode(cfg_mode), .cfg_thresh(cfg_thresh),
        .post_video_vsync(post_video_vsync), .post_video_hsync(post_video_hsync),
        .post_video_de(post_video_de), .post_video_edge(post_video_edge),
        .post_video_mag(post_video_mag),
        .post_video_xpos(post_video_xpos), .post_video_ypos(post_video_ypos)
    );

    always #5 video_pclk = ~video_pclk;
    assign outs = {post_video_vsync, post_video_hsync, post_video_de, post_video_xpos,
                   post_video_ypos, post_video_edge, post_video_mag};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int px(input int y, input int x);
        return int'(img[y][x]);
    endfunction

    function automatic logic [31:0] model(input logic vs, input logic hs, input logic de,
                                          input logic [PW-1:0] x, input logic [PW-1:0] y);
        int gx, gy, l1;
        longint l2, sel;
        logic e = 1'b0;
        logic [7:0] m = '0;
        int xi = int'(x), yi = int'(y);
        if (de && xi >= 2 && yi >= 2 && xi < IW) begin
            gx = (px(yi-2, xi) + 2*px(yi-1, xi) + px(yi, xi))
               - (px(yi-2, xi-2) + 2*px(yi-1, xi-2) + px(yi, xi-2));
            gy = (px(yi, xi-2) + 2*px(yi, xi-1) + px(yi, xi))
               - (px(yi-2, xi-2) + 2*px(yi-2, xi-1) + px(yi-2, xi));
            l1 = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
            l2 = longint'(gx) * gx + longint'(gy) * gy;
            sel = m_mode ? longint'(l1) : l2;
            e = sel >= longint'(m_th);
            m = 8'(l1 / 8);
        end
        return {vs, hs, de, x, y, e, m};
    endfunction

    always @(negedge video_pclk) begin
        exp_t e;
        if (!sys_rst_n) begin
            q.delete();
            check("reset_out", outs, 32'h0);
            m_th = '1;
            m_mode = 1'b0;
            m_skip = 1'b1;
            vs_prev = 1'b0;
        end else begin
            if (pre_video_vsync && !vs_prev) begin
                m_th = cfg_thresh;
                m_mode = cfg_mode;
                m_skip = 1'b0;
            end
            vs_prev = pre_video_vsync;
            q.push_back('{model(pre_video_vsync, pre_video_hsync, pre_video_de,
                                pre_video_xpos, pre_video_ypos), m_skip});
            if (q.size() > 5) begin
                e = q.pop_front();
                if (!e.skip) check("out", outs, e.v);
            end
        end
    end

    task automatic cyc(input logic vs, input logic hs, input logic de, input int x, input int y);
        pre_video_vsync = vs;
        pre_video_hsync = hs;
        pre_video_de    = de;
        pre_video_xpos  = PW'(x);
        pre_video_ypos  = PW'(y);
        pre_video_data  = de ? img[y][x] : '0;
        @(posedge video_pclk);
        #1;
    endtask

    task automatic frame(input int w, input int h, input int chg_row, input int rst_row);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0);
        for (int y = 0; y < h; y++) begin
            cyc(0, 1, 0, 0, y);
            cyc(0, 0, 0, 0, y);
            for (int x = 0; x < w; x++) begin
                if (y == chg_row && x == 0) cfg_thresh = '1;
                if (y == rst_row && x == w / 2)
                    fork
                        begin
                            #1 sys_rst_n = 1'b0;
                            #1 check("rst_async", outs, 32'h0);
                            #20 sys_rst_n = 1'b1;
                        end
                    join_none
                cyc(0, 0, 1, x, y);
            end
            repeat (4) cyc(0, 0, 0, 0, y);
        end
        repeat (8) cyc(0, 0, 0, 0, 0);
    endtask

    task automatic fill(input int kind);
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 640; x++)
                img[y][x] = kind == 0 ? 8'd100 : kind == 1 ? (x < 8 ? 8'd0 : 8'd255) : 8'($urandom);
    endtask

    initial begin
        repeat (3) @(posedge video_pclk);
        #1 sys_rst_n = 1'b1;
        fill(0); cfg_mode = 1'b1; cfg_thresh = GW'(1);
        frame(16, 8, -1, -1);
        fill(1); cfg_thresh = GW'(1020);
        frame(16, 8, -1, -1);
        cfg_mode = 1'b0; cfg_thresh = GW'(1040400);
        frame(16, 8, -1, -1);
        cfg_thresh = GW'(1040401);
        frame(16, 8, -1, -1);
        cfg_mode = 1'b1; cfg_thresh = '0;
        frame(16, 8, 4, -1);
        frame(16, 8, -1, -1);
        fill(2); cfg_mode = 1'($urandom); cfg_thresh = '0;
        frame(640, 4, -1, -1);
        for (int i = 0; i < 3; i++) begin
            fill(2);
            cfg_mode = 1'($urandom);
            cfg_thresh = cfg_mode ? GW'($urandom_range(0, 2040)) : GW'($urandom_range(0, 1040400));
            frame(24, 8, -1, i == 1 ? 3 : -1);
        end
        fill(2); cfg_mode = 1'b0; cfg_thresh = GW'(770);
        frame(24, 8, -1, -1);
        repeat (10) @(posedge video_pclk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sobel_edge_param.md
# sobel_edge_param

Parametrised Sobel edge detector for the grey-scale video path. It contains its own two-line buffer and 3×3 window, so it takes the raw pixel stream directly. Per pixel it outputs a binary edge flag and an 8-bit-scaled gradient magnitude. Data width, line length, norm (L1 or L2) and threshold are configurable; the threshold can change at run time, frame-synchronously. It sits between the grey-scale converter and the binarised-edge consumers (overlay, morphology).

## Interface
Parameters:
- `DATA_W`, 8: input pixel width.
- `IMG_W`, 640: maximum active line length; this is the line-buffer depth.
- `POS_W`, 10: coordinate width.
- `GRAD_W`, `2*DATA_W+6`: threshold and gradient width. Derived; do not override.

Ports:
- `video_pclk` in 1: the single clock.
- `sys_rst_n` in 1: reset, asynchronous, active-low.
- `pre_video_vsync` / `pre_video_hsync` / `pre_video_de` in 1 each: input syncs and data-enable.
- `pre_video_data` in `DATA_W`: input pixel.
- `pre_video_xpos` / `pre_video_ypos` in `POS_W` each: coordinates of the input pixel.
- `cfg_mode` in 1: 0 selects L2 (Gx²+Gy²); 1 selects L1 (|Gx|+|Gy|).
- `cfg_thresh` in `GRAD_W`: edge threshold, compared against the selected norm.
- `post_video_vsync` / `post_video_hsync` / `post_video_de` out 1 each: syncs and data-enable delayed by `LAT`.
- `post_video_edge` out 1: 1 when the selected norm ≥ the active threshold.
- `post_video_mag` out `DATA_W`: (|Gx|+|Gy|) >> 3, independent of mode.
- `post_video_xpos` / `post_video_ypos` out `POS_W` each: coordinates delayed by `LAT`.

## Operation
- **Line buffer:** two RAMs, each `IMG_W`×`DATA_W`, cascaded.
  - On each `de` cycle with xpos < `IMG_W`: read both at xpos, write line0 ← pixel, write line1 ← line0 old value (read-before-write).
  - The 3×3 window shifts only on `de` cycles.
- **Window alignment:** the window's bottom-right element is the current input pixel. Output coordinates are those of this pixel; the window centre is (x−1, y−1).
- **Gradients:**
  - Gx = (p13+2p23+p33) − (p11+2p21+p31).
  - Gy = (p31+2p32+p33) − (p11+2p12+p13).
  - Both are signed, `DATA_W+4` bits, and never overflow.
- **Norms:**
  - L1 = |Gx|+|Gy|, max 8·(2^DATA_W−1).
  - L2 = Gx²+Gy², which fits `GRAD_W` unsigned.
  - `post_video_mag` = L1>>3. It is exact, with no saturation needed.
- **Threshold and mode shadowing:** `cfg_thresh` and `cfg_mode` are captured into shadow registers on the rising edge of `pre_video_vsync`. All pixels of a frame use the shadow values. A mid-frame change takes effect from the next frame.
- **Border suppression:** edge=0 and mag=0 when any of the following holds:
  - x<2 or y<2 (window incomplete);
  - xpos ≥ `IMG_W` (not buffered);
  - `de`=0.
- **Blanking:** during `de`=0 the pipeline advances but the window does not shift. Outputs follow the delayed `de` and are forced to 0.

## Timing
- Latency `LAT` = 5 cycles, identical for every output. The stages are:
  1. RAM read and window shift;
  2. Gx/Gy;
  3. abs and square;
  4. sum;
  5. compare and scale register.
- Sidebands (`vsync`, `hsync`, `de`, `xpos`, `ypos`) pass through a 5-deep shift register.
- Throughput: one pixel per cycle, no back-pressure.
- Reset values:
  - all outputs 0;
  - window and pipeline registers 0;
  - shadow threshold = all-ones (no edges until the first vsync);
  - shadow mode = 0.
- RAM contents are not reset. The y<2 rule masks stale data after reset.
- Reset asserted mid-frame: outputs go to 0 immediately. After release, output stays suppressed until y≥2 of the current frame is reached.
- A `cfg` change in the same cycle as the vsync rising edge captures the new value.

## Structure
- The shared package `sobel_pkg` holds:
  - the mode constants `SOBEL_L2`=0 and `SOBEL_L1`=1;
  - the width function for `GRAD_W`;
  - the default threshold 770 (L2, 8-bit).
- Sub-module `sobel_window3x3`: the line RAMs plus the 3×3 window registers. It is parametrised by `DATA_W` and `IMG_W`, and outputs p11..p33 plus a window-valid flag.
- The top level contains the gradient pipeline, the shadow registers and the sideband delay.

## Test plan
- **Flat image:** 16×8 frame, all pixels 100, L1 mode, thresh 1 → edge=0 and mag=0 everywhere; `post_video_de` is `pre_video_de` delayed by exactly 5 cycles.
- **Vertical step, L1:** 16×8 frame, 0 for x<8 and 255 for x≥8, thresh 1020.
  - At y≥2, outputs at x=8 and x=9 → edge=1 and mag=127.
  - At all other x → edge=0 and mag=0.
- **L2 mode, same image:** thresh 1040400 → edge=1 at x=8,9. Thresh 1040401 → edge=0 everywhere.
- **Threshold shadowing:** change `cfg_thresh` from 0 to max at mid-frame row 4 → rows 4..7 are still unaffected (edges still reported). The next frame shows no edges.
- **Borders:** random 640×4 frame with thresh 0 → edge=1 only where x≥2 and y≥2.
- **Reset mid-frame:** pulse `sys_rst_n` low during row 3 → all outputs are 0 within the same cycle. The next frame reproduces the golden model exactly, starting from the first vsync edge.
